jtbubl_colmix: RTL and testbench

Palette stage directly downstream of the graphics line buffer. Takes the 8-bit colour index produced each pixel, looks it up in a CPU-writable 512-byte palette RAM (256 entries × 2 bytes), and drives 4-bit RGB to the video output. Blanking is applied and delayed to stay aligned with the pixels. The CPU gets full read/write access to the palette without stalling the video path.

---
 rtl/jtbubl_colmix.sv | 115 +++++++++++
 tb/tb_jtbubl_colmix.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtbubl_colmix.sv
// Palette stage for the graphics line buffer.
// An 8-bit colour index is looked up in a CPU-writable palette of 256 entries
// (two bytes each). The result is driven out as 4-bit RGB, and the blanking
// inputs are delayed so they stay aligned with the pixels.
// The palette is stored as two 256x8 banks:
//   even byte = {R, G}
//   odd byte  = {B, unused}
// The CPU and the video path each have their own port, so neither one ever
// stalls the other.
module jtbubl_colmix #(
    parameter int BLANK_DLY = 2,
    parameter     SIMFILE   = "pal.hex"
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       pxl_cen,
    input  logic       pal_cs,
    input  logic       cpu_rnw,
    input  logic [8:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [7:0] col_addr,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    // SIMFILE only names the preload image that a simulation harness may
    // place in the banks. The synthesised RAM starts with undefined contents.
    if (!(|SIMFILE)) begin : g_no_simfile
    end

    logic [7:0] even_mem [256];
    logic [7:0] odd_mem  [256];

    logic [7:0] cpu_row;
    logic       cpu_we;

    assign cpu_row = cpu_addr[8:1];
    assign cpu_we  = pal_cs & ~cpu_rnw;

    logic [7:0]           vid_rg;
    logic [3:0]           vid_b;
    logic [11:0]          pix_rgb;
    logic [BLANK_DLY-1:0] hb_line;
    logic [BLANK_DLY-1:0] vb_line;
    logic                 blank_ok;

    assign blank_ok = hb_line[BLANK_DLY-1] & vb_line[BLANK_DLY-1];

    // CPU writes go to the bank selected by cpu_addr[0]. Reset leaves the palette untouched.
    always_ff @(posedge clk) begin
        if (cpu_we && !cpu_addr[0]) even_mem[cpu_row] <= cpu_dout;
        if (cpu_we &&  cpu_addr[0]) odd_mem[cpu_row]  <= cpu_dout;
    end

    // CPU read port: registered, read-first, and held while pal_cs is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pal_dout <= 8'h00;
        end else if (pal_cs) begin
            pal_dout <= cpu_addr[0] ? odd_mem[cpu_row] : even_mem[cpu_row];
        end
    end

    // Video stage 0: read both banks at the incoming index and shift the blanking delay lines.
    // The banks are read in the same edge as any CPU write, so a colliding
    // write only becomes visible from the next pixel onwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_rg  <= 8'h00;
            vid_b   <= 4'h0;
            hb_line <= '0;
            vb_line <= '0;
        end else if (pxl_cen) begin
            vid_rg     <= even_mem[col_addr];
            vid_b      <= odd_mem[col_addr][7:4];
            hb_line[0] <= LHBL;
            vb_line[0] <= LVBL;
            for (int i = 1; i < BLANK_DLY; i++) begin
                hb_line[i] <= hb_line[i-1];
                vb_line[i] <= vb_line[i-1];
            end
        end
    end

    // Video stage 1: capture the looked-up colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_rgb <= 12'h000;
        end else if (pxl_cen) begin
            pix_rgb <= {vid_rg, vid_b};
        end
    end

    // Output stage: blank the colour, and register the delayed blanking next to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red      <= 4'h0;
            green    <= 4'h0;
            blue     <= 4'h0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            {red, green, blue} <= blank_ok ? pix_rgb : 12'h000;
            LHBL_dly           <= hb_line[BLANK_DLY-1];
            LVBL_dly           <= vb_line[BLANK_DLY-1];
        end
    end

endmodule

// File: tb/tb_jtbubl_colmix.sv
// Bench for jtbubl_colmix.
// A palette array plus a short pixel history models the expected outputs,
// and every clock the DUT outputs are compared against it. Directed
// sequences add literal expectations at the key points.
module tb_jtbubl_colmix;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pxl_cen = 1'b0;
    logic       pal_cs = 1'b0;
    logic       cpu_rnw = 1'b1;
    logic [8:0] cpu_addr = 9'h000;
    logic [7:0] cpu_dout = 8'h00;
    logic       LHBL = 1'b0;
    logic       LVBL = 1'b0;
    logic [7:0] col_addr = 8'h00;
    logic [7:0] pal_dout;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;

    jtbubl_colmix #(.BLANK_DLY(2), .SIMFILE("pal.hex")) dut (
        .rst      (rst),
        .clk      (clk),
        .pxl_cen  (pxl_cen),
        .pal_cs   (pal_cs),
        .cpu_rnw  (cpu_rnw),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .pal_dout (pal_dout),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .col_addr (col_addr),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Reference model: the byte-addressed palette, plus the pixels sampled
    // so far. A pixel becomes visible two samples after it was taken.
    typedef struct packed {
        logic       lh;
        logic       lv;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pix_t;

    logic [7:0] pal_m [512];
    pix_t       hist [$];
    logic [3:0] e_r, e_g, e_b;
    logic       e_lh, e_lv;
    logic [7:0] e_dout;

    // Model update on every edge, then a full compare just after it.
    always @(posedge clk) begin
        pix_t       nw;
        pix_t       old;
        logic [7:0] rg;
        logic [7:0] bb;
        if (rst) begin
            hist = {};
            hist.push_back('0);
            hist.push_back('0);
            e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
            e_lh = 1'b0; e_lv = 1'b0;
            e_dout = 8'h00;
        end else begin
            if (pal_cs) e_dout = pal_m[cpu_addr];
            if (pxl_cen) begin
                rg = pal_m[{col_addr, 1'b0}];
                bb = pal_m[{col_addr, 1'b1}];
                nw.lh = LHBL;
                nw.lv = LVBL;
                nw.r = rg[7:4];
                nw.g = rg[3:0];
                nw.b = bb[7:4];
                hist.push_back(nw);
                old = hist.pop_front();
                e_lh = old.lh;
                e_lv = old.lv;
                if (old.lh && old.lv) begin
                    e_r = old.r; e_g = old.g; e_b = old.b;
                end else begin
                    e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
                end
            end
        end
        if (pal_cs && !cpu_rnw) pal_m[cpu_addr] = cpu_dout;
        #1;
        chk("cyc_red",   {4'h0, red},   {4'h0, e_r});
        chk("cyc_green", {4'h0, green}, {4'h0, e_g});
        chk("cyc_blue",  {4'h0, blue},  {4'h0, e_b});
        chk("cyc_lhbl",  {7'h0, LHBL_dly}, {7'h0, e_lh});
        chk("cyc_lvbl",  {7'h0, LVBL_dly}, {7'h0, e_lv});
        chk("cyc_pal_dout", pal_dout, e_dout);
    end

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
        @(negedge clk);
        pal_cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic rd(input logic [8:0] a);
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
        @(negedge clk);
        pal_cs = 1'b0;
    endtask

    // One pixel: a single pxl_cen clock followed by three idle clocks.
    task automatic px(input logic [7:0] c, input logic lh, input logic lv);
        col_addr = c; LHBL = lh; LVBL = lv; pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_rgb(input string name, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        chk({name, "_r"}, {4'h0, red},   {4'h0, r});
        chk({name, "_g"}, {4'h0, green}, {4'h0, g});
        chk({name, "_b"}, {4'h0, blue},  {4'h0, b});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fill the whole palette with a known pattern; video is blanked meanwhile.
        for (int a = 0; a < 512; a++) wr(a[8:0], 8'(a * 7 + 3));

        // CPU write, then read back.
        wr(9'h010, 8'hA5);
        wr(9'h011, 8'h3C);
        rd(9'h010);
        chk("rd_010", pal_dout, 8'hA5);
        rd(9'h011);
        chk("rd_011", pal_dout, 8'h3C);
        // A write returns the old byte; the new byte is visible from the next access.
        wr(9'h020, 8'h55);
        chk("wr_old_020", pal_dout, 8'hE3);
        rd(9'h020);
        chk("rd_new_020", pal_dout, 8'h55);

        // Reset with random video and address inputs.
        rst = 1'b1;
        repeat (5) begin
            pxl_cen = 1'($urandom);
            LHBL = 1'($urandom);
            LVBL = 1'($urandom);
            col_addr = 8'($urandom);
            cpu_addr = 9'($urandom);
            @(negedge clk);
            chk("rst_red", {4'h0, red}, 8'h00);
            chk("rst_pal_dout", pal_dout, 8'h00);
            chk("rst_lhbl", {7'h0, LHBL_dly}, 8'h00);
            chk("rst_lvbl", {7'h0, LVBL_dly}, 8'h00);
        end
        pxl_cen = 1'b0;
        rst = 1'b0;
        px(8'h08, 1'b1, 1'b1);
        chk_rgb("post_rst_p1", 4'h0, 4'h0, 4'h0);
        px(8'h08, 1'b1, 1'b1);
        chk_rgb("post_rst_p2", 4'h0, 4'h0, 4'h0);
        px(8'h08, 1'b1, 1'b1);
        chk_rgb("post_rst_p3", 4'hA, 4'h5, 4'h3);

        // Horizontal blank for a single pixel.
        px(8'h08, 1'b0, 1'b1);
        chk("hb_n0", {7'h0, LHBL_dly}, 8'h01);
        px(8'h08, 1'b1, 1'b1);
        chk("hb_n1", {7'h0, LHBL_dly}, 8'h01);
        px(8'h08, 1'b1, 1'b1);
        chk("hb_n2", {7'h0, LHBL_dly}, 8'h00);
        chk_rgb("hb_n2", 4'h0, 4'h0, 4'h0);
        px(8'h08, 1'b1, 1'b1);
        chk("hb_n3", {7'h0, LHBL_dly}, 8'h01);
        chk_rgb("hb_n3", 4'hA, 4'h5, 4'h3);

        // Vertical blank for a single pixel.
        px(8'h08, 1'b1, 1'b0);
        px(8'h08, 1'b1, 1'b1);
        chk("vb_n1", {7'h0, LVBL_dly}, 8'h01);
        px(8'h08, 1'b1, 1'b1);
        chk("vb_n2", {7'h0, LVBL_dly}, 8'h00);
        chk_rgb("vb_n2", 4'h0, 4'h0, 4'h0);
        px(8'h08, 1'b1, 1'b1);
        chk("vb_n3", {7'h0, LVBL_dly}, 8'h01);
        chk_rgb("vb_n3", 4'hA, 4'h5, 4'h3);

        // CPU write to entry 0x08 in the same clock the pixel samples index 0x08.
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 9'h010; cpu_dout = 8'hFF;
        px(8'h08, 1'b1, 1'b1);
        px(8'h08, 1'b1, 1'b1);
        px(8'h08, 1'b1, 1'b1);
        chk_rgb("coll_old", 4'hA, 4'h5, 4'h3);
        px(8'h08, 1'b1, 1'b1);
        chk_rgb("coll_new", 4'hF, 4'hF, 4'h3);

        // Extreme indices, alternating 0x00 and 0xFF on every pixel.
        wr(9'h000, 8'h12);
        wr(9'h001, 8'h80);
        wr(9'h1FE, 8'hDE);
        wr(9'h1FF, 8'h70);
        for (int k = 0; k < 8; k++) begin
            px((k % 2 == 1) ? 8'hFF : 8'h00, 1'b1, 1'b1);
            if (k == 2) chk_rgb("ext_00", 4'h1, 4'h2, 4'h8);
            if (k == 3) chk_rgb("ext_ff", 4'hD, 4'hE, 4'h7);
        end

        // Mixed random traffic; the per-clock model compare covers it.
        for (int i = 0; i < 300; i++) begin
            pxl_cen  = ($urandom_range(0, 2) == 0);
            LHBL     = ($urandom_range(0, 5) != 0);
            LVBL     = ($urandom_range(0, 7) != 0);
            col_addr = 8'($urandom);
            pal_cs   = 1'($urandom);
            cpu_rnw  = 1'($urandom);
            cpu_addr = 9'($urandom);
            cpu_dout = 8'($urandom);
            @(negedge clk);
        end
        pal_cs = 1'b0; pxl_cen = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
